// File: rtl/spi_target_sync.sv
// SPI target with all SPI pins oversampled in the system clock domain.
// One-deep transmit holding register in front of the tx shifter; single-word rx output.
module spi_target_sync #(
    parameter int DATA_WIDTH  = 8,
    parameter int MODE        = 0,
    parameter int LSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  spi_cs_ni,
    input  logic                  spi_sck_i,
    input  logic                  spi_sd_i,
    output logic                  spi_sd_o,
    output logic                  spi_sd_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  underrun_o,
    output logic                  busy_o
);

    localparam logic CPOL = 1'(MODE >> 1);
    localparam logic CPHA = 1'(MODE);
    localparam logic LSB  = (LSB_FIRST != 0);
    localparam int   CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DATA_WIDTH - 1);
    localparam logic [2:0]    FILL_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic                   r_cs_prev;
    logic                   r_sck_prev;
    logic [2:0]             r_fill_cnt;
    logic                   r_armed;
    logic [CW-1:0]          r_bit_cnt;
    logic                   r_load_pend;
    logic [DATA_WIDTH-1:0]  r_rx_shift;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic                   r_rx_valid;
    logic [DATA_WIDTH-1:0]  r_tx_shift;
    logic [DATA_WIDTH-1:0]  r_hold;
    logic                   r_hold_full;
    logic                   r_underrun;

    logic                  w_cs;
    logic                  w_sck;
    logic                  w_sd;
    logic                  w_sync_ready;
    logic                  w_cs_fall;
    logic                  w_sck_rise;
    logic                  w_sck_fall;
    logic                  w_lead;
    logic                  w_trail;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_load;
    logic                  w_advance;
    logic                  w_hold_wr;
    logic [DATA_WIDTH-1:0] w_rx_next;
    logic [DATA_WIDTH-1:0] w_tx_shifted;

    assign w_cs  = r_cs_sync[SYNC_STAGES-1];
    assign w_sck = r_sck_sync[SYNC_STAGES-1];
    assign w_sd  = r_sd_sync[SYNC_STAGES-1];

    // The reset values in the synchronizer are not real samples; a CS fall is only
    // trusted once both the chain and the previous-value flop hold sampled pin values.
    assign w_sync_ready = (r_fill_cnt == FILL_DONE);
    assign w_cs_fall    = r_cs_prev & ~w_cs & w_sync_ready;
    assign w_sck_rise   = ~r_sck_prev & w_sck;
    assign w_sck_fall   = r_sck_prev & ~w_sck;
    assign w_lead       = CPOL ? w_sck_fall : w_sck_rise;
    assign w_trail      = CPOL ? w_sck_rise : w_sck_fall;
    assign w_sample     = r_armed & ~w_cs & (CPHA ? w_trail : w_lead);
    assign w_shift      = r_armed & ~w_cs & (CPHA ? w_lead : w_trail);

    assign w_load    = (w_shift & r_load_pend) | (~CPHA & w_cs_fall);
    assign w_advance = w_shift & ~w_load;
    // A word offered while a load is happening bypasses the holding register.
    assign w_hold_wr = tx_valid_i & ~r_hold_full & ~w_load;

    assign w_rx_next    = LSB ? {w_sd, r_rx_shift[DATA_WIDTH-1:1]}
                              : {r_rx_shift[DATA_WIDTH-2:0], w_sd};
    assign w_tx_shifted = LSB ? {1'b0, r_tx_shift[DATA_WIDTH-1:1]}
                              : {r_tx_shift[DATA_WIDTH-2:0], 1'b0};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= {SYNC_STAGES{CPOL}};
            r_sd_sync   <= '0;
            r_cs_prev   <= 1'b1;
            r_sck_prev  <= CPOL;
            r_fill_cnt  <= '0;
            r_armed     <= 1'b0;
            r_bit_cnt   <= CNT_MAX;
            r_load_pend <= 1'b0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_shift  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], spi_sd_i};
            r_cs_prev  <= w_cs;
            r_sck_prev <= w_sck;
            if (!w_sync_ready) begin
                r_fill_cnt <= r_fill_cnt + 3'd1;
            end
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;

            if (w_cs) begin
                // CS high abandons any partial word; the holding register is kept.
                r_armed     <= 1'b0;
                r_bit_cnt   <= CNT_MAX;
                r_load_pend <= 1'b0;
                r_rx_shift  <= '0;
                r_tx_shift  <= '0;
            end else begin
                if (w_cs_fall) begin
                    r_armed     <= 1'b1;
                    r_load_pend <= CPHA;
                end
                if (w_sample) begin
                    r_rx_shift <= w_rx_next;
                    if (r_bit_cnt == '0) begin
                        r_bit_cnt   <= CNT_MAX;
                        r_rx_data   <= w_rx_next;
                        r_rx_valid  <= 1'b1;
                        r_load_pend <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                if (w_load) begin
                    r_load_pend <= 1'b0;
                    if (r_hold_full) begin
                        r_tx_shift <= r_hold;
                    end else if (tx_valid_i) begin
                        r_tx_shift <= tx_data_i;
                    end else begin
                        r_tx_shift <= '0;
                        r_underrun <= 1'b1;
                    end
                end else if (w_advance) begin
                    r_tx_shift <= w_tx_shifted;
                end
            end

            if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (w_hold_wr) begin
                r_hold      <= tx_data_i;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign spi_sd_o    = LSB ? r_tx_shift[0] : r_tx_shift[DATA_WIDTH-1];
    assign spi_sd_oe_o = r_armed;
    assign busy_o      = r_armed;
    assign tx_ready_o  = ~r_hold_full;
    assign rx_data_o   = r_rx_data;
    assign rx_valid_o  = r_rx_valid;
    assign underrun_o  = r_underrun;

endmodule
